// File: rtl/i2c_regfile_ctrl_pkg.sv
// Package for the I2C register-file controller: state type, pointer width
// and the pointer auto-increment rule shared by the write and read paths.
`include "i2c_regfile_defs.vh"

package i2c_regfile_ctrl_pkg;

  localparam int PTR_W = `PTR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = `ST_IDLE,
    ST_GET_PTR = `ST_GET_PTR,
    ST_WR_DATA = `ST_WR_DATA
  } state_t;

  // Pointer increments modulo num_regs; a pointer already past the end
  // (set by the master) also lands on 0.
  function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] p,
                                                   input int num_regs);
    if (int'(p) >= num_regs - 1) return '0;
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// START/STOP condition detector for raw I2C pins.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   scl_in       : raw SCL pin level
//   sda_in       : raw SDA pin level
//   start_pulse  : one-cycle pulse, SDA fell while SCL high
//   stop_pulse   : one-cycle pulse, SDA rose while SCL high
// Each pin passes through a 2-flop synchronizer plus a previous-sample flop;
// the registered pulse appears 3 clk after the pin change.
module i2c_bus_cond_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic start_pulse,
  output logic stop_pulse
);

  logic scl_s1_reg, scl_s2_reg, scl_prev_reg;
  logic sda_s1_reg, sda_s2_reg, sda_prev_reg;
  logic start_reg, stop_reg;
  logic scl_high;

  // SCL must be high in both the current and previous sample so that an
  // SDA edge coinciding with an SCL edge is not mistaken for a condition.
  assign scl_high = scl_s2_reg && scl_prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Idle bus level is high on both lines.
      scl_s1_reg   <= 1'b1;
      scl_s2_reg   <= 1'b1;
      scl_prev_reg <= 1'b1;
      sda_s1_reg   <= 1'b1;
      sda_s2_reg   <= 1'b1;
      sda_prev_reg <= 1'b1;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_s1_reg   <= scl_in;
      scl_s2_reg   <= scl_s1_reg;
      scl_prev_reg <= scl_s2_reg;
      sda_s1_reg   <= sda_in;
      sda_s2_reg   <= sda_s1_reg;
      sda_prev_reg <= sda_s2_reg;
      start_reg    <= scl_high && sda_prev_reg && !sda_s2_reg;
      stop_reg     <= scl_high && !sda_prev_reg && sda_s2_reg;
    end
  end

  assign start_pulse = start_reg;
  assign stop_pulse  = stop_reg;

endmodule

// File: rtl/i2c_regfile_defs.vh
// Shared constants for the I2C register-file controller.
//   ST_IDLE / ST_GET_PTR / ST_WR_DATA : FSM state encodings
//   PTR_W                             : register pointer width in bits
`ifndef I2C_REGFILE_DEFS_VH
`define I2C_REGFILE_DEFS_VH

`define ST_IDLE    2'd0
`define ST_GET_PTR 2'd1
`define ST_WR_DATA 2'd2
`define PTR_W      8

`endif

// File: rtl/i2c_regfile_ctrl.sv
// EEPROM-style register file behind a 7-bit I2C slave user interface.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   scl_in, sda_in    : raw bus pins, watched for START/STOP
//   read_req          : slave is fetching a byte (ptr advances)
//   data_to_master    : registered reg[ptr], next byte for the slave to send
//   data_valid        : slave received a byte on data_from_master
//   data_from_master  : received byte
//   status_in         : read-only register values, reg NUM_RW at LSBs
//   regs_out          : R/W register contents, reg 0 at LSBs
//   wr_stb/addr/data  : one-cycle write notification for R/W registers
//   ptr               : current register pointer
module i2c_regfile_ctrl
  import i2c_regfile_ctrl_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter int         NUM_RW    = 8,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] OOR_VAL   = 8'hFF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            scl_in,
  input  logic                            sda_in,
  input  logic                            read_req,
  output logic [7:0]                      data_to_master,
  input  logic                            data_valid,
  input  logic [7:0]                      data_from_master,
  input  logic [8*(NUM_REGS-NUM_RW)-1:0]  status_in,
  output logic [8*NUM_RW-1:0]             regs_out,
  output logic                            wr_stb,
  output logic [7:0]                      wr_addr,
  output logic [7:0]                      wr_data,
  output logic [7:0]                      ptr
);

  localparam int PTR_SPAN = 2**PTR_W;

  logic start_pulse, stop_pulse;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             wr_en;

  logic [7:0] regs_reg [NUM_RW];
  logic [7:0] rd_arr   [PTR_SPAN];
  logic [7:0] data_to_master_reg;
  logic       wr_stb_reg;
  logic [7:0] wr_addr_reg, wr_data_reg;

  i2c_bus_cond_detect u_bus_cond (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    wr_en      = 1'b0;
    // A received byte takes priority over a concurrent read_req, so the
    // pointer moves only once.
    if (data_valid && state_reg != ST_IDLE) begin
      case (state_reg)
        ST_GET_PTR: begin
          ptr_next   = data_from_master;
          state_next = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wr_en    = int'(ptr_reg) < NUM_RW;
          ptr_next = ptr_advance(ptr_reg, NUM_REGS);
        end
        default: ;
      endcase
    end else if (read_req) begin
      ptr_next = ptr_advance(ptr_reg, NUM_REGS);
    end
    // Bus conditions override whatever the byte action chose for the state.
    if (start_pulse) begin
      state_next = ST_GET_PTR;
    end else if (stop_pulse) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RW; i++) regs_reg[i] <= RESET_VAL;
      wr_stb_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_stb_reg <= wr_en;
      if (wr_en) begin
        wr_addr_reg <= ptr_reg;
        wr_data_reg <= data_from_master;
      end
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_en && ptr_reg == PTR_W'(i)) regs_reg[i] <= data_from_master;
      end
    end
  end

  // Full pointer-space read map: R/W regs, then status, then OOR filler.
  genvar gi;
  generate
    for (gi = 0; gi < PTR_SPAN; gi++) begin : g_rd
      if (gi < NUM_RW) begin : g_rw
        assign rd_arr[gi] = regs_reg[gi];
      end else if (gi < NUM_REGS) begin : g_ro
        assign rd_arr[gi] = status_in[(gi-NUM_RW)*8 +: 8];
      end else begin : g_oor
        assign rd_arr[gi] = OOR_VAL;
      end
    end

    for (gi = 0; gi < NUM_RW; gi++) begin : g_out
      assign regs_out[gi*8 +: 8] = regs_reg[gi];
    end
  endgenerate

  // Registered every cycle so the byte at ptr is already stable when the
  // slave raises read_req.
  always_ff @(posedge clk) begin
    if (!rst_n) data_to_master_reg <= RESET_VAL;
    else        data_to_master_reg <= rd_arr[ptr_reg];
  end

  assign data_to_master = data_to_master_reg;
  assign wr_stb         = wr_stb_reg;
  assign wr_addr        = wr_addr_reg;
  assign wr_data        = wr_data_reg;
  assign ptr            = ptr_reg;

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
module tb_i2c_regfile_ctrl;

  localparam int NUM_REGS = 16;
  localparam int NUM_RW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic read_req = 1'b0;
  logic data_valid = 1'b0;
  logic [7:0] data_from_master = 8'h00;
  logic [8*(NUM_REGS-NUM_RW)-1:0] status_in = '0;
  logic [7:0] data_to_master, wr_addr, wr_data, ptr;
  logic [8*NUM_RW-1:0] regs_out;
  logic wr_stb;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, pointer, and transaction phase
  // (0 = not addressed, 1 = next byte is the pointer, 2 = bytes are data).
  logic [7:0] m_regs [NUM_RW];
  int m_ptr;
  int m_phase;

  always #5 clk = ~clk;

  i2c_regfile_ctrl #(
    .NUM_REGS (NUM_REGS),
    .NUM_RW   (NUM_RW),
    .RESET_VAL(8'h00),
    .OOR_VAL  (8'hFF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .scl_in           (scl_in),
    .sda_in           (sda_in),
    .read_req         (read_req),
    .data_to_master   (data_to_master),
    .data_valid       (data_valid),
    .data_from_master (data_from_master),
    .status_in        (status_in),
    .regs_out         (regs_out),
    .wr_stb           (wr_stb),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .ptr              (ptr)
  );

  function automatic int next_ptr(input int p);
    if (p >= NUM_REGS) return 0;
    return (p + 1) % NUM_REGS;
  endfunction

  function automatic logic [7:0] model_byte(input int p);
    if (p < NUM_RW) return m_regs[p];
    if (p < NUM_REGS) return status_in[(p-NUM_RW)*8 +: 8];
    return 8'hFF;
  endfunction

  function automatic logic [8*NUM_RW-1:0] model_regs_vec();
    logic [8*NUM_RW-1:0] v;
    for (int i = 0; i < NUM_RW; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_in = 1'b1; tick(3);
    scl_in = 1'b1; tick(4);
    sda_in = 1'b0; tick(5);
    scl_in = 1'b0; tick(3);
    m_phase = 1;
  endtask

  task automatic bus_stop();
    sda_in = 1'b0; tick(3);
    scl_in = 1'b1; tick(4);
    sda_in = 1'b1; tick(5);
    m_phase = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic exp_stb;
    int exp_addr;
    exp_stb  = (m_phase == 2) && (m_ptr < NUM_RW);
    exp_addr = m_ptr;
    @(posedge clk); #1;
    data_valid = 1'b1; data_from_master = b;
    @(posedge clk); #1;
    data_valid = 1'b0;
    checks++;
    if (wr_stb !== exp_stb || (exp_stb && (wr_addr !== 8'(exp_addr) || wr_data !== b))) begin
      errors++;
      $display("FAIL write_strobe: got stb=%0b addr=%0d data=%02h, expected stb=%0b addr=%0d data=%02h",
               wr_stb, wr_addr, wr_data, exp_stb, exp_addr, b);
    end
    if (m_phase == 1) begin
      m_ptr = b; m_phase = 2;
    end else if (m_phase == 2) begin
      if (m_ptr < NUM_RW) m_regs[m_ptr] = b;
      m_ptr = next_ptr(m_ptr);
    end
    tick(1);
    checks++;
    if (wr_stb !== 1'b0) begin
      errors++;
      $display("FAIL write_strobe_width: got stb=%0b, expected 0", wr_stb);
    end
  endtask

  task automatic read_byte();
    logic [7:0] got, exp;
    exp = model_byte(m_ptr);
    @(posedge clk); #1;
    got = data_to_master; read_req = 1'b1;
    @(posedge clk); #1;
    read_req = 1'b0;
    tick(1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL read_data: ptr=%0d got %02h, expected %02h", m_ptr, got, exp);
    end
    m_ptr = next_ptr(m_ptr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(3);
    rst_n = 1'b1; tick(1);
    for (int i = 0; i < NUM_RW; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_phase = 0;
    checks++;
    if (ptr !== 8'h00 || data_to_master !== 8'h00 || wr_stb !== 1'b0 ||
        wr_addr !== 8'h00 || wr_data !== 8'h00 || regs_out !== '0) begin
      errors++;
      $display("FAIL reset: ptr=%02h dtm=%02h stb=%0b addr=%02h data=%02h regs=%h, expected all zero",
               ptr, data_to_master, wr_stb, wr_addr, wr_data, regs_out);
    end
  endtask

  task automatic test_write_seq();
    bus_start();
    send_byte(8'h03);
    send_byte(8'hA5);
    send_byte(8'h5A);
    bus_stop();
    checks++;
    if (regs_out[3*8 +: 8] !== 8'hA5 || regs_out[4*8 +: 8] !== 8'h5A) begin
      errors++;
      $display("FAIL write_seq_regs: reg3=%02h reg4=%02h, expected a5 5a",
               regs_out[3*8 +: 8], regs_out[4*8 +: 8]);
    end
    checks++;
    if (ptr !== 8'd5) begin
      errors++;
      $display("FAIL write_seq_ptr: got %0d, expected 5", ptr);
    end
    // Bus is idle after STOP: a stray byte must not write.
    send_byte(8'hEE);
    checks++;
    if (regs_out !== model_regs_vec()) begin
      errors++;
      $display("FAIL write_seq_after_stop: regs=%h, expected %h", regs_out, model_regs_vec());
    end
  endtask

  task automatic test_read_repeated();
    bus_start();
    send_byte(8'h03);
    bus_start();
    read_byte();
    read_byte();
    read_byte();
    bus_stop();
    checks++;
    if (ptr !== 8'd6) begin
      errors++;
      $display("FAIL read_repeated_ptr: got %0d, expected 6", ptr);
    end
  endtask

  task automatic test_status_wrap();
    status_in = {8'hC3, 56'(($urandom() << 32) | $urandom())};
    bus_start();
    send_byte(8'h0F);
    bus_start();
    read_byte();
    read_byte();
    bus_stop();
    checks++;
    if (ptr !== 8'd1) begin
      errors++;
      $display("FAIL status_wrap_ptr: got %0d, expected 1", ptr);
    end
  endtask

  task automatic test_ro_drop();
    bus_start();
    send_byte(8'h0A);
    send_byte(8'h77);
    bus_stop();
    checks++;
    if (ptr !== 8'h0B || regs_out !== model_regs_vec()) begin
      errors++;
      $display("FAIL ro_drop: ptr=%02h regs=%h, expected ptr=0b regs=%h", ptr, regs_out, model_regs_vec());
    end
    bus_start();
    send_byte(8'h20);
    bus_start();
    read_byte();
    bus_stop();
    checks++;
    if (ptr !== 8'h00) begin
      errors++;
      $display("FAIL oor_wrap_ptr: got %02h, expected 00", ptr);
    end
  endtask

  task automatic test_idle_ignore();
    int p0;
    p0 = m_ptr;
    send_byte(8'($urandom()));
    send_byte(8'($urandom()));
    checks++;
    if (ptr !== 8'(p0) || regs_out !== model_regs_vec()) begin
      errors++;
      $display("FAIL idle_ignore: ptr=%02h regs=%h, expected ptr=%02h regs=%h",
               ptr, regs_out, 8'(p0), model_regs_vec());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      status_in = 64'(($urandom() << 32) | $urandom());
      bus_start();
      send_byte(8'($urandom_range(0, 40)));
      for (int k = 0, n = $urandom_range(0, 4); k < n; k++) send_byte(8'($urandom()));
      if ($urandom_range(0, 1) == 1) begin
        bus_start();
        for (int k = 0, n = $urandom_range(1, 4); k < n; k++) read_byte();
      end
      bus_stop();
      checks++;
      if (ptr !== 8'(m_ptr) || regs_out !== model_regs_vec()) begin
        errors++;
        $display("FAIL random_txn %0d: ptr=%02h regs=%h, expected ptr=%02h regs=%h",
                 t, ptr, regs_out, 8'(m_ptr), model_regs_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    // Make sure at least one register is non-default before the reset.
    bus_start();
    send_byte(8'h01);
    send_byte(8'h3C);
    bus_start();
    send_byte(8'h02);
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(1);
    for (int i = 0; i < NUM_RW; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_phase = 0;
    checks++;
    if (ptr !== 8'h00 || regs_out !== '0 || data_to_master !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: ptr=%02h regs=%h dtm=%02h, expected zeros", ptr, regs_out, data_to_master);
    end
    send_byte(8'h99);
    checks++;
    if (ptr !== 8'h00 || regs_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_ignore: ptr=%02h regs=%h, expected zeros", ptr, regs_out);
    end
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_read_repeated();
    test_status_wrap();
    test_ro_drop();
    test_idle_ignore();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
